// File: rtl/hex_pkg.sv
// Shared hex processor types plus the system-call codes, stack layout and controller states.
// Pure declarations: no logic, no latency, no flow control.
package hex_pkg;

    localparam int DATA_W  = 32;
    localparam int WADDR_W = 12;

    typedef logic [DATA_W-1:0]  data_t;
    typedef logic [WADDR_W-1:0] waddr_t;
    typedef logic [DATA_W-1:0]  syscall_t;

    localparam syscall_t SYS_EXIT  = syscall_t'(0);
    localparam syscall_t SYS_WRITE = syscall_t'(1);
    localparam syscall_t SYS_READ  = syscall_t'(2);

    // Word offsets from the stack pointer: result slot, then the two arguments
    localparam waddr_t SYS_RES_OFF  = waddr_t'(1);
    localparam waddr_t SYS_ARG0_OFF = waddr_t'(2);
    localparam waddr_t SYS_ARG1_OFF = waddr_t'(3);

    localparam data_t SYS_EOF = 32'hFFFF_FFFF;

    typedef enum logic [3:0] {
        SC_IDLE,
        SC_LD_SP,
        SC_LD_ARG0,
        SC_LD_ARG1,
        SC_WRITE,
        SC_READ,
        SC_ST_RES,
        SC_EXIT,
        SC_DONE
    } syscall_ctrl_state_t;

endpackage

// File: rtl/syscall_ctrl.sv
// Syscall sequencer and data-memory arbiter; stall is asserted combinationally in the SVC cycle.
// Latency: write byte offered 4 cycles after SVC, exit flag 3 cycles after; READ store 1 cycle after handshake.
// Backpressure: holds the output byte until i_out_ready; waits for i_in_valid only when SYSCALL_READ_EN is defined.
module syscall_ctrl
    import hex_pkg::*;
#(
    parameter int unsigned SP_ADDR = 1
) (
    input  logic     i_clk,
    input  logic     i_rst_n,
    input  logic     i_syscall_valid,
    input  syscall_t i_syscall,
    output logic     o_cpu_stall,
    input  logic     i_cpu_d_valid,
    input  logic     i_cpu_d_we,
    input  waddr_t   i_cpu_d_addr,
    input  data_t    i_cpu_d_data,
    output data_t    o_cpu_d_data,
    output logic     o_d_valid,
    output logic     o_d_we,
    output waddr_t   o_d_addr,
    output data_t    o_d_data,
    input  data_t    i_d_data,
    output logic     o_out_valid,
    output logic [7:0] o_out_data,
    output logic [7:0] o_out_stream,
    input  logic     i_out_ready,
    input  logic     i_in_valid,
    input  logic [7:0] i_in_data,
    output logic     o_in_ready,
    output logic     o_exit,
    output data_t    o_exit_code
);

    syscall_ctrl_state_t state, state_nxt;

    syscall_t   code_q;
    waddr_t     sp_q;
    data_t      arg0_q;
    logic [7:0] arg1_q;
    data_t      res_val;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= SC_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            code_q <= '0;
            sp_q   <= '0;
            arg0_q <= '0;
            arg1_q <= '0;
        end else begin
            if (state == SC_IDLE && i_syscall_valid) code_q <= i_syscall;
            if (state == SC_LD_SP)   sp_q   <= i_d_data[WADDR_W-1:0];
            if (state == SC_LD_ARG0) arg0_q <= i_d_data;
            if (state == SC_LD_ARG1) arg1_q <= i_d_data[7:0];
        end
    end

`ifdef SYSCALL_READ_EN
    data_t res_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            res_q <= '0;
        end else if (state == SC_READ && i_in_valid) begin
            res_q <= {24'b0, i_in_data};
        end
    end

    assign res_val = res_q;
`else
    // No host input path: every read reports end-of-file
    logic unused_in;
    assign unused_in = ^{i_in_valid, i_in_data};
    assign res_val   = SYS_EOF;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            SC_IDLE:    if (i_syscall_valid) state_nxt = SC_LD_SP;
            SC_LD_SP: begin
                if (code_q == SYS_EXIT || code_q == SYS_WRITE) begin
                    state_nxt = SC_LD_ARG0;
                end else if (code_q == SYS_READ) begin
`ifdef SYSCALL_READ_EN
                    state_nxt = SC_READ;
`else
                    state_nxt = SC_ST_RES;
`endif
                end else begin
                    state_nxt = SC_DONE;
                end
            end
            SC_LD_ARG0: state_nxt = (code_q == SYS_WRITE) ? SC_LD_ARG1 : SC_EXIT;
            SC_LD_ARG1: state_nxt = SC_WRITE;
            SC_WRITE:   if (i_out_ready) state_nxt = SC_DONE;
`ifdef SYSCALL_READ_EN
            SC_READ:    if (i_in_valid) state_nxt = SC_ST_RES;
`endif
            SC_ST_RES:  state_nxt = SC_DONE;
            SC_EXIT:    state_nxt = SC_EXIT;
            SC_DONE:    state_nxt = SC_IDLE;
            default:    state_nxt = SC_IDLE;
        endcase
    end

    assign o_cpu_d_data = i_d_data;

    always_comb begin
        o_cpu_stall  = 1'b1;
        o_d_valid    = 1'b0;
        o_d_we       = 1'b0;
        o_d_addr     = '0;
        o_d_data     = '0;
        o_out_valid  = 1'b0;
        o_out_data   = '0;
        o_out_stream = '0;
        o_in_ready   = 1'b0;
        o_exit       = 1'b0;
        o_exit_code  = '0;
        case (state)
            SC_IDLE: begin
                // SVC itself makes no memory access, so passthrough stays safe while stalling
                o_cpu_stall = i_syscall_valid;
                o_d_valid   = i_cpu_d_valid;
                o_d_we      = i_cpu_d_we;
                o_d_addr    = i_cpu_d_addr;
                o_d_data    = i_cpu_d_data;
            end
            SC_LD_SP: begin
                o_d_valid = 1'b1;
                o_d_addr  = waddr_t'(SP_ADDR);
            end
            SC_LD_ARG0: begin
                o_d_valid = 1'b1;
                o_d_addr  = sp_q + SYS_ARG0_OFF;
            end
            SC_LD_ARG1: begin
                o_d_valid = 1'b1;
                o_d_addr  = sp_q + SYS_ARG1_OFF;
            end
            SC_WRITE: begin
                o_out_valid  = 1'b1;
                o_out_data   = arg0_q[7:0];
                o_out_stream = arg1_q;
            end
`ifdef SYSCALL_READ_EN
            SC_READ:  o_in_ready = 1'b1;
`endif
            SC_ST_RES: begin
                o_d_valid = 1'b1;
                o_d_we    = 1'b1;
                o_d_addr  = sp_q + SYS_RES_OFF;
                o_d_data  = res_val;
            end
            SC_EXIT: begin
                o_exit      = 1'b1;
                o_exit_code = arg0_q;
            end
            SC_DONE:  o_cpu_stall = 1'b0;
            default:  o_cpu_stall = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_syscall_ctrl.sv
// Directed bench for syscall_ctrl with a combinational word memory and a scoreboard of expected host/memory results.
module tb_syscall_ctrl;
    import hex_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       syscall_valid;
    syscall_t   syscall;
    logic       cpu_stall;
    logic       cpu_d_valid, cpu_d_we;
    waddr_t     cpu_d_addr;
    data_t      cpu_d_wdata, cpu_d_rdata;
    logic       d_valid, d_we;
    waddr_t     d_addr;
    data_t      d_wdata, d_rdata;
    logic       out_valid, out_ready;
    logic [7:0] out_data, out_stream;
    logic       in_valid, in_ready;
    logic [7:0] in_data;
    logic       exit_flag;
    data_t      exit_code;

    data_t mem [0:(1<<WADDR_W)-1];
    logic [63:0] sb_q [$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign d_rdata = mem[d_addr];

    syscall_ctrl #(.SP_ADDR(1)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_syscall_valid(syscall_valid), .i_syscall(syscall),
        .o_cpu_stall(cpu_stall),
        .i_cpu_d_valid(cpu_d_valid), .i_cpu_d_we(cpu_d_we),
        .i_cpu_d_addr(cpu_d_addr), .i_cpu_d_data(cpu_d_wdata),
        .o_cpu_d_data(cpu_d_rdata),
        .o_d_valid(d_valid), .o_d_we(d_we), .o_d_addr(d_addr),
        .o_d_data(d_wdata), .i_d_data(d_rdata),
        .o_out_valid(out_valid), .o_out_data(out_data),
        .o_out_stream(out_stream), .i_out_ready(out_ready),
        .i_in_valid(in_valid), .i_in_data(in_data), .o_in_ready(in_ready),
        .o_exit(exit_flag), .o_exit_code(exit_code)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sb_check(input string tag, input logic [63:0] obs);
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: observed %0h expected <scoreboard empty>", tag, obs);
        end else begin
            chk(tag, obs, sb_q.pop_front());
        end
    endtask

    // Advance one clock; memory commits the write request presented during the finished cycle
    task automatic tick();
        logic   wr;
        waddr_t wa;
        data_t  wd;
        wr = d_valid && d_we;
        wa = d_addr;
        wd = d_wdata;
        @(posedge clk);
        #1;
        if (wr) mem[wa] = wd;
    endtask

    task automatic do_write(input logic [7:0] stream, input logic [7:0] byt, input int hold);
        int n;
        mem[1]     = 32'h0000_0100;
        mem[12'h102] = {24'h123456, byt};
        mem[12'h103] = {24'hABCD00, stream};
        sb_q.push_back({48'h0, stream, byt});
        syscall       = SYS_WRITE;
        syscall_valid = 1'b1;
        #1;
        chk("write_stall_T", cpu_stall, 1'b1);
        n = 0;
        do begin
            tick();
            #1;
            n++;
        end while (!out_valid && n < 10);
        chk("write_latency", n, 4);
        for (int i = 0; i < hold; i++) begin
            chk("write_hold_data", {out_valid, out_stream, out_data}, {1'b1, stream, byt});
            chk("write_hold_stall", cpu_stall, 1'b1);
            tick();
            #1;
        end
        out_ready = 1'b1;
        #1;
        sb_check("write_byte", {out_stream, out_data});
        tick();
        out_ready = 1'b0;
        #1;
        chk("write_done_stall", cpu_stall, 1'b0);
        chk("write_done_valid", out_valid, 1'b0);
        syscall_valid = 1'b0;
        tick();
        #1;
        chk("write_idle_stall", cpu_stall, 1'b0);
    endtask

    initial begin
        int n;
        int low_cnt;
        data_t exp_res;
        for (int i = 0; i < (1 << WADDR_W); i++) mem[i] = '0;
        rst_n = 1'b0; syscall_valid = 1'b0; syscall = '0;
        cpu_d_valid = 1'b0; cpu_d_we = 1'b0; cpu_d_addr = '0; cpu_d_wdata = '0;
        out_ready = 1'b0; in_valid = 1'b0; in_data = '0;
        tick(); tick();
        cpu_d_valid = 1'b1; cpu_d_addr = 12'h010;
        #1;
        chk("rst_stall", cpu_stall, 1'b0);
        chk("rst_host", {out_valid, in_ready, exit_flag}, 3'b000);
        chk("rst_codes", {exit_code, out_data, out_stream}, 48'h0);
        chk("rst_passthru", {d_valid, d_we, d_addr}, {2'b10, 12'h010});
        rst_n = 1'b1;
        tick();

        // Processor access with no syscall: same-cycle passthrough both ways
        mem[12'h010] = 32'h0000_1234;
        cpu_d_valid = 1'b1; cpu_d_we = 1'b0; cpu_d_addr = 12'h010;
        #1;
        chk("pt_rdata", cpu_d_rdata, 32'h1234);
        chk("pt_stall", cpu_stall, 1'b0);
        tick();
        cpu_d_we = 1'b1; cpu_d_addr = 12'h020; cpu_d_wdata = 32'hBEEF;
        #1;
        chk("pt_wr_req", {d_valid, d_we, d_addr, d_wdata}, {2'b11, 12'h020, 32'hBEEF});
        tick();
        cpu_d_valid = 1'b0; cpu_d_we = 1'b0;
        chk("pt_wr_mem", mem[12'h020], 32'hBEEF);

        do_write(8'h00, 8'h41, 3);

        // READ: result lands in sp+1
        mem[1] = 32'h0000_0100;
        mem[12'h101] = 32'h0;
`ifdef SYSCALL_READ_EN
        exp_res = 32'h0000_005A;
`else
        exp_res = 32'hFFFF_FFFF;
`endif
        sb_q.push_back({20'h0, 12'h101, exp_res});
        syscall = SYS_READ; syscall_valid = 1'b1; in_data = 8'h5A;
        #1;
        chk("read_stall_T", cpu_stall, 1'b1);
        tick(); #1;
        chk("read_ldsp_ready", in_ready, 1'b0);
        tick(); #1;
`ifdef SYSCALL_READ_EN
        chk("read_ready_T2", in_ready, 1'b1);
        tick(); #1;
        tick();
        in_valid = 1'b1;
        #1;
        tick();
        in_valid = 1'b0;
        #1;
`endif
        chk("read_st_ready", in_ready, 1'b0);
        sb_check("read_store", {20'h0, d_wdata === exp_res ? d_addr : 12'hFFF, d_wdata});
        chk("read_st_we", {d_valid, d_we, cpu_stall}, 3'b111);
        tick(); #1;
        chk("read_done_stall", cpu_stall, 1'b0);
        chk("read_mem", mem[12'h101], exp_res);
        syscall_valid = 1'b0;
        tick();

        // Unknown code: LD_SP then DONE, no host activity
        syscall = syscall_t'(3); syscall_valid = 1'b1;
        #1;
        chk("unk_stall_T", cpu_stall, 1'b1);
        tick(); #1;
        chk("unk_ldsp", {cpu_stall, d_valid, d_we, d_addr}, {3'b110, 12'h001});
        chk("unk_host", {out_valid, in_ready, exit_flag}, 3'b000);
        tick(); #1;
        chk("unk_done", cpu_stall, 1'b0);
        syscall_valid = 1'b0;
        tick();

        // Reset while a byte is being offered
        mem[1] = 32'h0000_0100; mem[12'h102] = 32'h42; mem[12'h103] = 32'h1;
        syscall = SYS_WRITE; syscall_valid = 1'b1;
        n = 0;
        do begin
            tick();
            #1;
            n++;
        end while (!out_valid && n < 10);
        chk("rstmid_reached_write", out_valid, 1'b1);
        rst_n = 1'b0; syscall_valid = 1'b0; cpu_d_addr = 12'h055;
        #1;
        chk("rstmid_out_valid", out_valid, 1'b0);
        chk("rstmid_stall", cpu_stall, 1'b0);
        chk("rstmid_passthru", d_addr, 12'h055);
        tick();
        rst_n = 1'b1;
        tick();
        do_write(8'h03, 8'h7E, 1);

        // EXIT: terminal, stall held
        mem[1] = 32'h0000_0100; mem[12'h102] = 32'h7;
        sb_q.push_back(64'h7);
        syscall = SYS_EXIT; syscall_valid = 1'b1;
        #1;
        tick(); #1;
        tick(); #1;
        chk("exit_T2", exit_flag, 1'b0);
        tick(); #1;
        chk("exit_T3", exit_flag, 1'b1);
        sb_check("exit_code", exit_code);
        low_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            tick(); #1;
            if (!cpu_stall || !exit_flag) low_cnt++;
        end
        chk("exit_hold", low_cnt, 0);
        rst_n = 1'b0; syscall_valid = 1'b0;
        #1;
        chk("exit_cleared", {exit_flag, exit_code}, 33'h0);
        chk("sb_empty", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
